// File: rtl/edge_pkg.sv
// Shared types and defaults for the edge-filter datapath: arbiter states,
// requester identifiers and the round-robin pick used when both ports request.
package edge_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 8;
    localparam int LAT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_RD = 2'd1,
        ISSUE_WR = 2'd2,
        WAIT     = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_id_t;

    // Only meaningful when at least one request is present; a tie goes to the
    // port that did not win last time.
    function automatic req_id_t rr_pick(input logic rd_q, input logic wr_q, input req_id_t last);
        req_id_t pick;
        if (rd_q && wr_q) begin
            pick = (last == REQ_RD) ? REQ_WR : REQ_RD;
        end else if (wr_q) begin
            pick = REQ_WR;
        end else begin
            pick = REQ_RD;
        end
        return pick;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Loadable down-counter used to time the fixed SRAM latency; load has
// priority over decrement and the count saturates at zero.
module flex_counter
    import edge_pkg::*;
#(
    parameter int WIDTH = LAT_CNT_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count register: load, decrement towards zero, or hold
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != ZERO)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == ZERO);

endmodule

// File: rtl/sram_arbiter_checker.sv
// Protocol invariants of the arbiter's registered outputs.
module sram_arbiter_checker (
    input logic clk,
    input logic n_rst,
    input logic rd_gnt,
    input logic wr_gnt,
    input logic rd_done,
    input logic wr_done,
    input logic mem_read_en,
    input logic mem_write_en
);

    a_en_excl:   assert property (@(posedge clk) disable iff (!n_rst) !(mem_read_en && mem_write_en));
    a_gnt_excl:  assert property (@(posedge clk) disable iff (!n_rst) !(rd_gnt && wr_gnt));
    a_done_excl: assert property (@(posedge clk) disable iff (!n_rst) !(rd_done && wr_done));
    a_rd_strobe: assert property (@(posedge clk) disable iff (!n_rst) rd_gnt == mem_read_en);
    a_wr_strobe: assert property (@(posedge clk) disable iff (!n_rst) wr_gnt == mem_write_en);

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing the single-port pixel SRAM between the window
// loader (read) and the result writer (write), timing the fixed memory latency.
module sram_arbiter
    import edge_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [LAT_CNT_W-1:0] LAT_VAL = LAT_CNT_W'(MEM_LAT);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE = 4'd1;
    localparam logic [LAT_CNT_W-1:0] CNT_TWO = 4'd2;

    arb_state_t state_r, next_state_s;
    req_id_t    last_grant_r, access_id_s;

    logic [LAT_CNT_W-1:0] cnt_s;
    logic                 cnt_zero_s, cnt_load_s, cnt_dec_s;
    logic                 last_wait_next_s, rd_done_next_s, wr_done_next_s;
    logic [ADDR_W-1:0]    addr_next_s;
    logic [DATA_W-1:0]    wdata_next_s, rdata_next_s;

    logic              rd_gnt_r, wr_gnt_r, rd_done_r, wr_done_r;
    logic              mem_read_en_r, mem_write_en_r, busy_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r, rd_data_r;

    flex_counter #(.WIDTH(LAT_CNT_W)) u_lat_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .load_val (LAT_VAL),
        .count    (cnt_s),
        .zero     (cnt_zero_s)
    );

    // State register and round-robin history
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= IDLE;
            last_grant_r <= REQ_WR;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                ISSUE_RD: last_grant_r <= REQ_RD;
                ISSUE_WR: last_grant_r <= REQ_WR;
                default:  last_grant_r <= last_grant_r;
            endcase
        end
    end

    // Next-state and latency-counter control
    always_comb begin
        next_state_s = state_r;
        cnt_load_s   = 1'b0;
        cnt_dec_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (rd_req || wr_req) begin
                    next_state_s = (rr_pick(rd_req, wr_req, last_grant_r) == REQ_RD) ? ISSUE_RD : ISSUE_WR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE_RD, ISSUE_WR: begin
                next_state_s = WAIT;
                cnt_load_s   = 1'b1;
            end
            WAIT: begin
                cnt_dec_s = 1'b1;
                // zero is a safety exit in case the counter was never loaded
                if (cnt_zero_s || (cnt_s == CNT_ONE)) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; done is raised on the edge that
    // enters the final WAIT cycle so it is visible in that cycle
    always_comb begin
        access_id_s      = last_grant_r;
        last_wait_next_s = 1'b0;
        case (state_r)
            ISSUE_RD: begin
                access_id_s      = REQ_RD;
                last_wait_next_s = (LAT_VAL == CNT_ONE);
            end
            ISSUE_WR: begin
                access_id_s      = REQ_WR;
                last_wait_next_s = (LAT_VAL == CNT_ONE);
            end
            WAIT: begin
                access_id_s      = last_grant_r;
                last_wait_next_s = (cnt_s == CNT_TWO);
            end
            default: begin
                access_id_s      = last_grant_r;
                last_wait_next_s = 1'b0;
            end
        endcase

        rd_done_next_s = last_wait_next_s && (access_id_s == REQ_RD);
        wr_done_next_s = last_wait_next_s && (access_id_s == REQ_WR);

        if (next_state_s == ISSUE_RD) begin
            addr_next_s  = rd_addr;
            wdata_next_s = mem_wdata_r;
        end else if (next_state_s == ISSUE_WR) begin
            addr_next_s  = wr_addr;
            wdata_next_s = wr_data;
        end else begin
            addr_next_s  = mem_addr_r;
            wdata_next_s = mem_wdata_r;
        end

        if (rd_done_next_s) begin
            rdata_next_s = mem_rdata;
        end else begin
            rdata_next_s = rd_data_r;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_gnt_r       <= 1'b0;
            wr_gnt_r       <= 1'b0;
            rd_done_r      <= 1'b0;
            wr_done_r      <= 1'b0;
            mem_read_en_r  <= 1'b0;
            mem_write_en_r <= 1'b0;
            busy_r         <= 1'b0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_wdata_r    <= {DATA_W{1'b0}};
            rd_data_r      <= {DATA_W{1'b0}};
        end else begin
            rd_gnt_r       <= (next_state_s == ISSUE_RD);
            wr_gnt_r       <= (next_state_s == ISSUE_WR);
            mem_read_en_r  <= (next_state_s == ISSUE_RD);
            mem_write_en_r <= (next_state_s == ISSUE_WR);
            busy_r         <= (next_state_s != IDLE);
            rd_done_r      <= rd_done_next_s;
            wr_done_r      <= wr_done_next_s;
            mem_addr_r     <= addr_next_s;
            mem_wdata_r    <= wdata_next_s;
            rd_data_r      <= rdata_next_s;
        end
    end

    assign rd_gnt       = rd_gnt_r;
    assign wr_gnt       = wr_gnt_r;
    assign rd_done      = rd_done_r;
    assign wr_done      = wr_done_r;
    assign rd_data      = rd_data_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign mem_read_en  = mem_read_en_r;
    assign mem_write_en = mem_write_en_r;
    assign busy         = busy_r;

    sram_arbiter_checker u_checker (
        .clk          (clk),
        .n_rst        (n_rst),
        .rd_gnt       (rd_gnt_r),
        .wr_gnt       (wr_gnt_r),
        .rd_done      (rd_done_r),
        .wr_done      (wr_done_r),
        .mem_read_en  (mem_read_en_r),
        .mem_write_en (mem_write_en_r)
    );

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port pixel SRAM between two requesters during the filter phase:
  - the window loader (read port `rd_*`) fetching neighbourhood pixels around the current anchor;
  - the result writer (write port `wr_*`) storing filtered pixels.
- Sits between the filter controller's datapath and the SRAM model.
- Serialises accesses, applies round-robin priority, times the fixed memory latency, and returns done/data strobes.

Parameters:
- ADDR_W, 18, SRAM address width in bits (pixel index y*WIDTH+x).
- DATA_W, 8, pixel data width in bits.
- MEM_LAT, 2, cycles from command issue to read data valid or write complete; legal range 1..15.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rd_req  in  1  read request; held high until rd_done
- rd_addr  in  ADDR_W  read address; stable while rd_req is high
- rd_gnt  out  1  one-cycle pulse: read command issued to SRAM
- rd_done  out  1  one-cycle pulse: rd_data valid
- rd_data  out  DATA_W  captured read data; holds until next rd_done
- wr_req  in  1  write request; held high until wr_done
- wr_addr  in  ADDR_W  write address; stable while wr_req is high
- wr_data  in  DATA_W  write data; stable while wr_req is high
- wr_gnt  out  1  one-cycle pulse: write command issued
- wr_done  out  1  one-cycle pulse: write complete
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_read_en  out  1  SRAM read strobe, one cycle per access
- mem_write_en  out  1  SRAM write strobe, one cycle per access
- mem_rdata  in  DATA_W  SRAM read data; valid MEM_LAT cycles after mem_read_en
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous, active-low.
- Reset values: every output is 0 (including rd_data and mem_addr). State is IDLE. last_grant is WRITE, so the first contended grant goes to read. Latency counter is 0.
- All outputs are registered.
- States:
  - IDLE, ISSUE_RD, ISSUE_WR, WAIT.
  - Requests are sampled only in IDLE.
- Transitions out of IDLE:
  - rd_req only -> ISSUE_RD.
  - wr_req only -> ISSUE_WR.
  - Both -> whichever is not last_grant.
  - Neither -> stay in IDLE.
- ISSUE_x (exactly 1 cycle):
  - x_gnt=1, mem_x_en=1, mem_addr=x_addr; mem_wdata=wr_data for writes.
  - last_grant <= x; counter loaded with MEM_LAT.
  - Next state: WAIT.
- WAIT:
  - Counter decrements each cycle; mem enables are 0.
  - mem_addr and mem_wdata hold their values.
  - In the cycle the counter reaches 0: the relevant x_done pulses (1 cycle), rd_data <= mem_rdata on reads, and the next state is IDLE.
- Timing:
  - Request seen in IDLE at cycle t -> gnt at t+1 -> done at t+1+MEM_LAT.
  - Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Re-requests: a requester that keeps req high after done is treated as a new request in the following IDLE cycle; it is not an error.
- Starvation: under continuous contention, strict alternation (R,W,R,W...) is required; neither port waits more than one access.
- Requests arriving mid-access are queued by level and seen at the next IDLE. They are never lost or duplicated.
- Reset mid-operation: an asynchronous return to IDLE; the in-flight access is abandoned and no done is issued. Requesters must reissue.
- Never both mem_read_en and mem_write_en in the same cycle; never both gnt in the same cycle.
- MEM_LAT=1: WAIT lasts exactly one cycle.

Decomposition:
- Shared package edge_pkg:
  - typedef enum arb_state_t {IDLE, ISSUE_RD, ISSUE_WR, WAIT};
  - typedef enum req_id_t {REQ_RD, REQ_WR};
  - default ADDR_W/DATA_W constants shared with controller.
- One sub-module: flex_counter (load/decrement latency counter with zero flag, width 4).
- FSM and muxing live in sram_arbiter.

Test Plan:
1. Reset then idle: assert n_rst=0 -> all outputs 0, busy=0; release with no requests -> still 0 after 10 cycles.
2. Single read, MEM_LAT=2: rd_req=1 with rd_addr=0x00123 at cycle 0, mem_rdata=0xA5 -> rd_gnt and mem_read_en at cycle 1 with mem_addr=0x00123, rd_done at cycle 3 with rd_data=0xA5.
3. Single write: wr_addr=0x3FFFF, wr_data=0x7E -> wr_gnt and mem_write_en with mem_addr=0x3FFFF and mem_wdata=0x7E, then wr_done exactly MEM_LAT cycles later; rd_* stay 0.
4. Contention: rd_req and wr_req held high together from reset -> grant order R,W,R,W over 4 accesses, one access per 4 cycles; enables are never simultaneous.
5. Late arrival: wr_req rises during a read's WAIT -> write is granted in the cycle after IDLE, and the read completes unaffected.
6. Reset mid-access: drop n_rst during WAIT -> outputs 0 immediately and no rd_done appears; a re-request after release completes normally.
